// File: rtl/adder_pkg.sv
// Shared types and constants for the adder stage and its downstream frame accumulator.
package adder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Width of one adder result, {carry, sum}.
    localparam int ADD_RES_W = 9;

    localparam int DEFAULT_FRAME_LEN = 4;
    localparam int DEFAULT_ACC_WIDTH = 16;

endpackage

// File: rtl/adder_frame_accumulator.sv
// Sums FRAME_LEN adder results per frame and hands the total, with a sticky wrap
// flag, to the next stage under a valid/ready handshake.
module adder_frame_accumulator
    import adder_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [7:0]           sum_in,
    input  logic                 carry_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 clear_in,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;

    logic [ACC_WIDTH:0]     sample_ext;
    logic [ACC_WIDTH:0]     sum_full;
    logic                   accept;
    logic                   consume;

    // One extra bit on the add exposes the wrap out of the accumulator.
    assign sample_ext = {{(ACC_WIDTH + 1 - ADD_RES_W){1'b0}}, carry_in, sum_in};
    assign sum_full   = {1'b0, acc_q} + sample_ext;

    // Handshakes qualify on the registered flags, so no input reaches an output.
    assign accept  = valid_in && ready_q;
    assign consume = valid_q && ready_in;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        valid_d = valid_q;

        if (clear_in) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            ready_d = 1'b1;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    // Raises ready on the first edge after reset release.
                    ready_d = 1'b1;
                    if (accept) begin
                        acc_d = sum_full[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | sum_full[ACC_WIDTH];
                        if (cnt_q == CNT_WIDTH'(FRAME_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = DONE;
                            ready_d = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (consume) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_out    = ready_q;
    assign valid_out    = valid_q;
    assign acc_out      = acc_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_adder_frame_accumulator.sv
// Self-checking bench: a 16-bit and a 10-bit accumulator share one upstream adder
// and are compared every cycle against a frame-level sum model.
module tb_adder_frame_accumulator;

    localparam int FL   = 4;
    localparam int W_HI = 16;
    localparam int W_LO = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic cin = 1'b0;
    logic valid = 1'b0, clr = 1'b0, rdy = 1'b0;

    logic [7:0] sum_w;
    logic       carry_w;

    logic            ready_hi, valid_hi, ovf_hi;
    logic [W_HI-1:0] acc_hi;
    logic            ready_lo, valid_lo, ovf_lo;
    logic [W_LO-1:0] acc_lo;

    int total = 0;
    int bad   = 0;

    // Upstream 8-bit adder stage with carry-in.
    assign {carry_w, sum_w} = 9'(a) + 9'(b) + 9'(cin);

    always #5 clk = ~clk;

    adder_frame_accumulator #(.ACC_WIDTH(W_HI), .FRAME_LEN(FL)) dut_hi (
        .clk_in(clk), .rst_n_in(rst_n), .sum_in(sum_w), .carry_in(carry_w),
        .valid_in(valid), .ready_out(ready_hi), .clear_in(clr), .acc_out(acc_hi),
        .overflow_out(ovf_hi), .valid_out(valid_hi), .ready_in(rdy)
    );

    adder_frame_accumulator #(.ACC_WIDTH(W_LO), .FRAME_LEN(FL)) dut_lo (
        .clk_in(clk), .rst_n_in(rst_n), .sum_in(sum_w), .carry_in(carry_w),
        .valid_in(valid), .ready_out(ready_lo), .clear_in(clr), .acc_out(acc_lo),
        .overflow_out(ovf_lo), .valid_out(valid_lo), .ready_in(rdy)
    );

    // Reference model: the samples of the current frame, whether a result is pending,
    // and whether the block is out of reset long enough to be ready.
    int frame_q[$];
    bit m_has_result = 1'b0;
    bit m_up = 1'b0;

    function automatic int frame_sum();
        int s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int s, input bit v, input bit c, input bit r);
        a     = 8'(s / 2);
        b     = 8'(s / 2);
        cin   = 1'(s % 2);
        valid = v;
        clr   = c;
        rdy   = r;
    endtask

    task automatic compare_model();
        int s;
        bit er;
        er = m_up && !m_has_result;
        s  = frame_sum();
        check("ready_hi", 32'(ready_hi), 32'(er));
        check("ready_lo", 32'(ready_lo), 32'(er));
        check("valid_hi", 32'(valid_hi), 32'(m_has_result));
        check("valid_lo", 32'(valid_lo), 32'(m_has_result));
        if (m_has_result) begin
            check("acc_hi", 32'(acc_hi), 32'(s % (1 << W_HI)));
            check("ovf_hi", 32'(ovf_hi), 32'(s >= (1 << W_HI)));
            check("acc_lo", 32'(acc_lo), 32'(s % (1 << W_LO)));
            check("ovf_lo", 32'(ovf_lo), 32'(s >= (1 << W_LO)));
        end
    endtask

    // One clock: the model consumes the inputs seen at the edge, then both DUTs are compared.
    task automatic tick();
        int smp;
        bit er;
        smp = int'(a) + int'(b) + int'(cin);
        er  = m_up && !m_has_result;
        @(posedge clk);
        #1;
        if (clr) begin
            frame_q.delete();
            m_has_result = 1'b0;
        end else if (!m_has_result) begin
            if (valid && er) begin
                frame_q.push_back(smp);
                if (frame_q.size() == FL) m_has_result = 1'b1;
            end
        end else if (rdy) begin
            m_has_result = 1'b0;
            frame_q.delete();
        end
        m_up = 1'b1;
        compare_model();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_acc_hi"},   32'(acc_hi),   32'd0);
        check({tag, "_acc_lo"},   32'(acc_lo),   32'd0);
        check({tag, "_ovf_lo"},   32'(ovf_lo),   32'd0);
        check({tag, "_valid_hi"}, 32'(valid_hi), 32'd0);
        frame_q.delete();
        m_has_result = 1'b0;
        m_up = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check({tag, "_ready_after"}, 32'(ready_hi), 32'd1);
    endtask

    typedef struct {
        int smp;
        bit v;
        bit c;
        bit r;
        bit ev;
        bit er;
        int eacc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int rises;
        bit prev;

        // Basic frame, then backpressure with ignored valid pulses, then a 4x1 frame.
        tbl[0]  = '{smp: 'h010, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[1]  = '{smp: 'h1FF, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[2]  = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[3]  = '{smp: 'h100, v: 1, c: 0, r: 0, ev: 1, er: 0, eacc: 'h310};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 1, er: 0, eacc: 'h310};
        tbl[9]  = '{smp: 'h000, v: 0, c: 0, r: 1, ev: 0, er: 1, eacc: 0};
        tbl[10] = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[11] = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[12] = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 0, er: 1, eacc: 0};
        tbl[13] = '{smp: 'h001, v: 1, c: 0, r: 0, ev: 1, er: 0, eacc: 4};
        tbl[14] = '{smp: 'h000, v: 0, c: 0, r: 1, ev: 0, er: 1, eacc: 0};

        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        check("reset_valid", 32'(valid_hi), 32'd0);
        check("reset_acc",   32'(acc_hi),   32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("reset_ready", 32'(ready_hi), 32'd1);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].smp, tbl[i].v, tbl[i].c, tbl[i].r);
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(valid_hi), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_ready", i), 32'(ready_hi), 32'(tbl[i].er));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_acc", i), 32'(acc_hi), 32'(tbl[i].eacc));
                check($sformatf("tbl%0d_ovf", i), 32'(ovf_hi), 32'd0);
            end
        end

        // Overflow on the 10-bit instance, consume, then a clean frame.
        for (int i = 0; i < 4; i++) begin
            drive('h1FF, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("ovf_acc_lo", 32'(acc_lo), 32'h3FC);
        check("ovf_flag_lo", 32'(ovf_lo), 32'd1);
        check("ovf_acc_hi", 32'(acc_hi), 32'd2044);
        check("ovf_flag_hi", 32'(ovf_hi), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("post_ovf_acc_lo", 32'(acc_lo), 32'd4);
        check("post_ovf_flag_lo", 32'(ovf_lo), 32'd0);

        // Reset while holding an overflowed result.
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive('h1FF, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("pre_rst_ovf_lo", 32'(ovf_lo), 32'd1);
        async_reset("rst_done");

        // Reset mid-frame: the sample count must restart.
        for (int i = 0; i < 2; i++) begin
            drive(100, 1'b1, 1'b0, 1'b0);
            tick();
        end
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("rst_mid_acc", 32'(acc_hi), 32'd4);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();

        // Clear beats a simultaneous sample.
        drive(5, 1'b1, 1'b0, 1'b0); tick();
        drive(6, 1'b1, 1'b0, 1'b0); tick();
        drive(7, 1'b1, 1'b1, 1'b0); tick();
        check("clr_valid", 32'(valid_hi), 32'd0);
        check("clr_ready", 32'(ready_hi), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drive(i, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("clr_valid_after", 32'(valid_hi), 32'd1);
        check("clr_acc", 32'(acc_hi), 32'd10);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();
        check("consume_valid", 32'(valid_hi), 32'd0);

        // Gapped input with 0..3 idle cycles between samples.
        rises = 0;
        prev  = valid_hi;
        for (int k = 0; k < 4; k++) begin
            drive('h0FF, 1'b1, 1'b0, 1'b0);
            tick();
            if (valid_hi && !prev) rises++;
            prev = valid_hi;
            for (int g = 0; g < k; g++) begin
                drive(0, 1'b0, 1'b0, 1'b0);
                tick();
                if (valid_hi && !prev) rises++;
                prev = valid_hi;
            end
        end
        check("gap_acc", 32'(acc_hi), 32'h3FC);
        check("gap_ovf", 32'(ovf_hi), 32'd0);
        check("gap_rises", 32'(rises), 32'd1);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(int'($urandom_range(0, 511)), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_frame_accumulator.md
Name: adder_frame_accumulator

Overview:
- Downstream consumer of the 8-bit adder stage.
- Captures each 9-bit adder result {carry, sum} under a valid/ready handshake and accumulates FRAME_LEN results into a wider running total.
- Presents the frame total with a sticky overflow flag to the next stage under its own valid/ready handshake.
- Turns the combinational adder output into a framed, flow-controlled stream.

Parameters:
- ACC_WIDTH, 16, width of the accumulator and of acc_out. Legal range is 9 or more.
- FRAME_LEN, 4, number of adder results summed per frame. Legal range is 2 or more.
- CNT_WIDTH, $clog2(FRAME_LEN), width of the internal sample counter.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- sum_in  input  8  sum from the adder stage.
- carry_in  input  1  carry from the adder stage. The sample value is {carry_in, sum_in}, range 0..511.
- valid_in  input  1  upstream sample valid.
- ready_out  output  1  block can accept a sample this cycle.
- clear_in  input  1  synchronous abort of the current frame.
- acc_out  output  ACC_WIDTH  frame total, valid while valid_out=1.
- overflow_out  output  1  frame total wrapped modulo 2^ACC_WIDTH. Valid while valid_out=1.
- valid_out  output  1  frame result available.
- ready_in  input  1  downstream accepts the result.

Behaviour:
- Reset (rst_n_in=0, asynchronous, any state):
  - State becomes ACCUM.
  - acc_out=0, overflow_out=0, valid_out=0, internal count=0.
  - ready_out=1 from the first clock edge after rst_n_in is released.
- States are ACCUM and DONE.
- ACCUM:
  - ready_out=1, valid_out=0.
  - A sample is accepted when valid_in && ready_out. On acceptance:
    - acc <= (acc + zero-extended {carry_in, sum_in}) mod 2^ACC_WIDTH.
    - If the true sum is at least 2^ACC_WIDTH, overflow <= 1. The flag is sticky for the frame.
    - count <= count+1.
  - When the accepted sample is the FRAME_LEN-th (count == FRAME_LEN-1), the next state is DONE and count <= 0.
  - valid_in=0 cycles hold all state. Gaps between samples are allowed.
- DONE:
  - ready_out=0, valid_out=1. acc_out and overflow_out are held stable.
  - valid_in is ignored.
  - When valid_out && ready_in, the result is consumed. On the next edge: acc=0, overflow=0, valid_out=0, state returns to ACCUM.
  - No sample is accepted in the consume cycle.
- Latency: valid_out rises on the edge that accepts the last sample, so it is visible in the cycle after the last handshake.
- Result throughput: at most one frame per FRAME_LEN+1 cycles.
- clear_in=1 in any state, on the next edge: acc=0, overflow=0, count=0, valid_out=0, state ACCUM.
  - clear_in has priority over a simultaneous sample acceptance (the sample is dropped) and over a simultaneous result consume.
- ready_out and valid_out are decoded from state registers only. There is no combinational path from valid_in or ready_in to any output.
- acc_out drives the accumulator register directly. Its value is only meaningful while valid_out=1.

Decomposition:
- Shared package, adder_pkg:
  - State enum {ACCUM, DONE}.
  - Adder result width constant ADD_RES_W = 9.
  - Default FRAME_LEN and ACC_WIDTH constants.
- No sub-module. The accumulate add, the counter and the 2-state FSM sit inline in one module.
- The bench instantiates the 8-bit adder stage upstream to drive sum_in/carry_in.

Test Plan:
- Reset values: assert rst_n_in mid-frame, asynchronously between edges. Required: acc_out=0, overflow_out=0 and valid_out=0 immediately, without waiting for a clock edge; ready_out=1 after release.
- Basic frame: back-to-back samples 0x010, 0x1FF, 0x001, 0x100. Required: valid_out=1 in the cycle after the 4th accept, acc_out=0x0310 (784), overflow_out=0, ready_out=0.
- Backpressure: same frame with ready_in=0 for 5 cycles. Required:
  - acc_out=0x0310 and valid_out=1 held stable; valid_in pulses ignored.
  - When ready_in=1, the next cycle shows valid_out=0 and ready_out=1.
  - The next frame of 4×0x001 gives acc_out=4.
- Overflow with ACC_WIDTH=10: four samples of 0x1FF. Required: acc_out=0x3FC (2044 mod 1024), overflow_out=1. The following frame 0x001 ×4 gives acc_out=4, overflow_out=0.
- Clear priority: accept 0x005 and 0x006, then clear_in=1 together with valid_in=1 carrying 0x007. Required:
  - 0x007 is dropped and the count restarts.
  - The subsequent samples 0x001, 0x002, 0x003, 0x004 give acc_out=10.
- Gapped input: samples 0x0FF, 0x0FF, 0x0FF, 0x0FF with 0–3 idle cycles between them (valid_in=0). Required: acc_out=0x3FC, overflow_out=0, exactly one valid_out assertion.
